// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: shared widths, opcode/state enums and decode helper for tiny_cpu.
// Optional feature macro used by the design: TINY_CPU_HALT_EN.
package tiny_cpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR = 4'h8, OP_ADI = 4'h9, OP_SBI = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JNZ = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    OPCODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    MEMRD   = 3'd4,
    HALT    = 3'd5
  } state_e;

  // Opcodes whose operand is a memory address read in the MEMRD cycle.
  function automatic logic is_mem_rd(input opcode_e op);
    return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/tiny_cpu_if.sv
// tiny_cpu_if: CPU <-> memory/IO bus.
//   rw       : 1 = read, 0 = write (master drives)
//   addr     : 6-bit address (master drives)
//   data_out : write data, always the accumulator (master drives)
//   data_in  : synchronous read data, one cycle after addr (slave drives)
interface tiny_cpu_if;
  import tiny_cpu_pkg::*;

  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport master (output rw, output addr, output data_out, input data_in);
  modport slave  (input rw, input addr, input data_out, output data_in);
endinterface

// File: rtl/tiny_cpu_alu.sv
// tiny_cpu_alu: combinational accumulator ALU.
//   i_a, i_opnd : accumulator and operand
//   i_op        : current opcode
//   i_c         : current carry flag (passed through by non-arithmetic ops)
//   o_result    : new accumulator value
//   o_z, o_c    : new zero flag, new carry/borrow flag
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_opnd,
  input  opcode_e           i_op,
  input  logic              i_c,
  output logic [DATA_W-1:0] o_result,
  output logic              o_z,
  output logic              o_c
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Extra MSB of the difference is the unsigned borrow (i_a < i_opnd).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_opnd};
  assign w_diff = {1'b0, i_a} - {1'b0, i_opnd};

  always_comb begin
    o_result = i_a;
    o_c      = i_c;
    case (i_op)
      OP_LDI, OP_LDA: o_result = i_opnd;
      OP_ADD, OP_ADI: begin
        o_result = w_sum[DATA_W-1:0];
        o_c      = w_sum[DATA_W];
      end
      OP_SUB, OP_SBI: begin
        o_result = w_diff[DATA_W-1:0];
        o_c      = w_diff[DATA_W];
      end
      OP_AND:  o_result = i_a & i_opnd;
      OP_OR:   o_result = i_a | i_opnd;
      OP_XOR:  o_result = i_a ^ i_opnd;
      default: ;
    endcase
  end

  assign o_z = (o_result == '0);

endmodule

// File: rtl/tiny_cpu.sv
// tiny_cpu: 8-bit accumulator CPU with two-byte instructions and a
// multi-cycle FSM (FETCH, OPCODE, OPERAND, EXEC, MEMRD[, HALT]).
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : tiny_cpu_if master (rw, addr, data_out out; data_in in)
// Macro TINY_CPU_HALT_EN: when defined, HLT enters a permanent HALT state;
// otherwise HLT behaves as a 4-cycle NOP.
module tiny_cpu
  import tiny_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  tiny_cpu_if.master bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_opr;
  opcode_e           r_ir;
  logic              r_z;
  logic              r_c;

  logic [DATA_W-1:0] w_alu_opnd;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_z;
  logic              w_alu_c;
  logic              w_a_we;
  logic              w_take;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:   w_state_nxt = OPCODE;
      OPCODE:  w_state_nxt = OPERAND;
      OPERAND: w_state_nxt = EXEC;
      EXEC: begin
        if (is_mem_rd(r_ir)) w_state_nxt = MEMRD;
`ifdef TINY_CPU_HALT_EN
        else if (r_ir == OP_HLT) w_state_nxt = HALT;
`endif
        else w_state_nxt = FETCH;
      end
      MEMRD:   w_state_nxt = FETCH;
`ifdef TINY_CPU_HALT_EN
      HALT:    w_state_nxt = HALT;
`endif
      default: w_state_nxt = FETCH;
    endcase
  end

  // Bus outputs: decoded from state only, so a store still drives rw=0
  // in a cycle where reset is asserted.
  always_comb begin
    bus.addr = r_pc;
    bus.rw   = 1'b1;
    case (r_state)
      OPCODE: bus.addr = r_pc + ADDR_W'(1);
      EXEC: begin
        if (r_ir == OP_STA) begin
          bus.addr = r_opr[ADDR_W-1:0];
          bus.rw   = 1'b0;
        end else if (is_mem_rd(r_ir)) begin
          bus.addr = r_opr[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  assign bus.data_out = r_a;

  // Immediates use the operand byte; memory ops use the RAM read data.
  assign w_alu_opnd = (r_state == MEMRD) ? bus.data_in : r_opr;
  assign w_a_we     = (r_state == MEMRD) ||
                      ((r_state == EXEC) && (r_ir inside {OP_LDI, OP_ADI, OP_SBI}));

  // Branch condition, evaluated in EXEC
  always_comb begin
    w_take = 1'b0;
    if (r_state == EXEC) begin
      case (r_ir)
        OP_JMP:  w_take = 1'b1;
        OP_JZ:   w_take = r_z;
        OP_JNZ:  w_take = ~r_z;
        OP_JC:   w_take = r_c;
        default: w_take = 1'b0;
      endcase
    end
  end

  tiny_cpu_alu u_alu (
    .i_a      (r_a),
    .i_opnd   (w_alu_opnd),
    .i_op     (r_ir),
    .i_c      (r_c),
    .o_result (w_alu_res),
    .o_z      (w_alu_z),
    .o_c      (w_alu_c)
  );

  // Architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= '0;
      r_a   <= '0;
      r_opr <= '0;
      r_ir  <= OP_NOP;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      if (r_state == OPCODE) r_ir <= opcode_e'(bus.data_in[3:0]);
      if (r_state == OPERAND) begin
        r_opr <= bus.data_in;
        r_pc  <= r_pc + ADDR_W'(2);
      end
      if (w_take) r_pc <= r_opr[ADDR_W-1:0];
      if (w_a_we) begin
        r_a <= w_alu_res;
        r_z <= w_alu_z;
        r_c <= w_alu_c;
      end
    end
  end

endmodule

// File: tb/tb_tiny_cpu.sv
// tb_tiny_cpu: self-checking bench for tiny_cpu with a 64-byte synchronous
// memory model and a store scoreboard (expected {cycle, addr, data}).
module tb_tiny_cpu;
  import tiny_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_req = 1'b0;
  logic [7:0] mem  [64];
  logic [7:0] prog [64];

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] t_addr [256];
  logic       t_rw   [256];
  logic [7:0] t_dout [256];

  typedef struct {
    int         cyc;
    logic [5:0] a;
    logic [7:0] d;
  } st_t;
  st_t sb[$];

  tiny_cpu_if bus ();

  tiny_cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, write when rw=0
  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= prog[i];
    end else if (!bus.rw) begin
      mem[bus.addr] <= bus.data_out;
    end
    bus.data_in <= mem[bus.addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 64; i++) prog[i] = 8'h00;
  endtask

  task automatic put(input int a, input logic [7:0] b0, input logic [7:0] b1);
    prog[a % 64]       = b0;
    prog[(a + 1) % 64] = b1;
  endtask

  task automatic exp_store(input int cyc, input logic [5:0] a, input logic [7:0] d);
    st_t e;
    e.cyc = cyc;
    e.a   = a;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Reset for three edges, loading memory on the first; returns just after
  // the last edge with reset high, so the next cycle is cycle 0.
  task automatic do_reset(input bit chk_rst);
    reset  = 1'b1;
    ld_req = 1'b1;
    @(posedge clk);
    #1 ld_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (chk_rst) begin
      check("rst_addr", 32'(bus.addr), 32'h0);
      check("rst_rw", 32'(bus.rw), 32'h1);
      check("rst_dout", 32'(bus.data_out), 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Record n cycles of bus activity and score every store
  task automatic run(input int n);
    st_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t_addr[k] = bus.addr;
      t_rw[k]   = bus.rw;
      t_dout[k] = bus.data_out;
      if (!bus.rw) begin
        if (sb.size() == 0) begin
          check("st_extra_cyc", 32'(k), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("st_cyc", 32'(k), 32'(e.cyc));
          check("st_addr", 32'(bus.addr), 32'(e.a));
          check("st_data", 32'(bus.data_out), 32'(e.d));
        end
      end
    end
  endtask

  task automatic sb_drain(input string tag);
    check(tag, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    // LDI 0x05; STA 0x20; HLT
    clr_prog();
    put(0, 8'h01, 8'h05);
    put(2, 8'h03, 8'h20);
    put(4, 8'h0F, 8'h00);
    do_reset(1'b1);
    exp_store(7, 6'h20, 8'h05);
    run(20);
    check("c0_addr", 32'(t_addr[0]), 32'h00);
    check("c1_addr", 32'(t_addr[1]), 32'h01);
    check("ldi_a", 32'(t_dout[4]), 32'h05);
    sb_drain("sta_left");

    // LDI 0xF0; ADD [0x10]=0x20; JC 0x00
    clr_prog();
    put(0, 8'h01, 8'hF0);
    put(2, 8'h04, 8'h10);
    put(4, 8'h0E, 8'h00);
    prog[6'h10] = 8'h20;
    do_reset(1'b0);
    run(16);
    check("add_rdaddr", 32'(t_addr[7]), 32'h10);
    check("add_a", 32'(t_dout[9]), 32'h10);
    check("jc_taken", 32'(t_addr[13]), 32'h00);
    sb_drain("add_left");

    // LDI 3; SBI 3; JNZ 0; JZ 0x20; @0x20: JC 0; LDI 0x77; STA 0x30
    clr_prog();
    put(0, 8'h01, 8'h03);
    put(2, 8'h0A, 8'h03);
    put(4, 8'h0D, 8'h00);
    put(6, 8'h0C, 8'h20);
    put(6'h20, 8'h0E, 8'h00);
    put(6'h22, 8'h01, 8'h77);
    put(6'h24, 8'h03, 8'h30);
    put(6'h26, 8'h0F, 8'h00);
    do_reset(1'b0);
    exp_store(27, 6'h30, 8'h77);
    run(32);
    check("sbi_a", 32'(t_dout[8]), 32'h00);
    check("jnz_fall", 32'(t_addr[12]), 32'h06);
    check("jz_taken", 32'(t_addr[16]), 32'h20);
    sb_drain("jz_left");

    // Countdown: LDI 3; loop: SBI 1; STA 0x20; JNZ loop; HLT
    clr_prog();
    put(0, 8'h01, 8'h03);
    put(2, 8'h0A, 8'h01);
    put(4, 8'h03, 8'h20);
    put(6, 8'h0D, 8'h02);
    put(8, 8'h0F, 8'h00);
    do_reset(1'b0);
    exp_store(11, 6'h20, 8'h02);
    exp_store(23, 6'h20, 8'h01);
    exp_store(35, 6'h20, 8'h00);
`ifdef TINY_CPU_HALT_EN
    run(60);
    for (int k = 44; k < 60; k += 5) check("halt_addr", 32'(t_addr[k]), 32'h0A);
`else
    run(160);
    check("post_hlt_addr", 32'(t_addr[45]), 32'h0B);
    check("pc1_top", 32'(t_addr[149]), 32'h3F);
    check("pc_wrap", 32'(t_addr[152]), 32'h00);
`endif
    sb_drain("cnt_left");

    // Logic/sub ops, odd jump target, JZ, JMP self-loop
    clr_prog();
    put(6'h00, 8'h02, 8'h1B);
    put(6'h02, 8'h06, 8'h1C);
    put(6'h04, 8'h03, 8'h21);
    put(6'h06, 8'h07, 8'h1D);
    put(6'h08, 8'h08, 8'h1E);
    put(6'h0A, 8'h05, 8'h1F);
    put(6'h0C, 8'h0E, 8'h0F);
    prog[6'h0E] = 8'h0F;
    put(6'h0F, 8'h03, 8'h22);
    put(6'h11, 8'h09, 8'h04);
    put(6'h13, 8'h0C, 8'h17);
    put(6'h15, 8'h0F, 8'h00);
    put(6'h17, 8'h03, 8'h23);
    put(6'h19, 8'h0B, 8'h19);
    prog[6'h1B] = 8'hC3;
    prog[6'h1C] = 8'h5A;
    prog[6'h1D] = 8'h81;
    prog[6'h1E] = 8'hFF;
    prog[6'h1F] = 8'h40;
    do_reset(1'b0);
    exp_store(13, 6'h21, 8'h42);
    exp_store(36, 6'h22, 8'hFC);
    exp_store(48, 6'h23, 8'h00);
    run(58);
    check("jc_odd", 32'(t_addr[33]), 32'h0F);
    check("jz_odd", 32'(t_addr[45]), 32'h17);
    check("jmp_loop0", 32'(t_addr[53]), 32'h19);
    check("jmp_loop1", 32'(t_addr[57]), 32'h19);
    sb_drain("alu_left");

    // JMP 0x3F: operand fetch wraps to address 0
    clr_prog();
    put(0, 8'h0B, 8'h3F);
    prog[6'h3F] = 8'h01;
    do_reset(1'b0);
    run(14);
    check("jmp_3f", 32'(t_addr[4]), 32'h3F);
    check("pc1_wrap", 32'(t_addr[5]), 32'h00);
    check("wrap_ldi_a", 32'(t_dout[8]), 32'h0B);
    check("pc2_wrap", 32'(t_addr[8]), 32'h01);
    check("after_f", 32'(t_addr[12]), 32'h03);
`ifdef TINY_CPU_HALT_EN
    check("halt_hold", 32'(t_addr[13]), 32'h03);
`else
    check("f_is_nop", 32'(t_addr[13]), 32'h04);
`endif
    sb_drain("wrap_left");

    // Reset pulse in a store's EXEC cycle
    clr_prog();
    put(0, 8'h01, 8'h05);
    put(2, 8'h03, 8'h20);
    prog[6'h20] = 8'hEE;
    do_reset(1'b0);
    exp_store(7, 6'h20, 8'h05);
    run(8);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_st_mem", 32'(mem[6'h20]), 32'h05);
    exp_store(7, 6'h20, 8'h05);
    run(12);
    check("rst_st_rw", 32'(t_rw[0]), 32'h1);
    check("rst_st_addr", 32'(t_addr[0]), 32'h00);
    check("rst_st_a", 32'(t_dout[0]), 32'h00);
    check("rst_st_c1", 32'(t_addr[1]), 32'h01);
    sb_drain("rst_st_left");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
